// File: rtl/pkt_buf_pkg.sv
// rtl/pkt_buf_pkg.sv - shared constants, read FSM encoding and pointer width helper for pkt_buf
// PKT_BUF_LEN_HDR_EN adds the HDR read state.
package pkt_buf_pkg;

    localparam int DEF_DEPTH     = 32;
    localparam int DEF_MAX_PKT   = 16;
    localparam int DEF_LEN_DEPTH = 8;
    localparam int LEN_W         = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef PKT_BUF_LEN_HDR_EN
        ST_HDR  = 2'd1,
`endif
        ST_SEND = 2'd2
    } rd_state_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pkt_buf_len_fifo.sv
// rtl/pkt_buf_len_fifo.sv - synchronous FIFO of committed packet lengths with full/empty flags
module pkt_buf_len_fifo
    import pkt_buf_pkg::*;
#(
    parameter int DEPTH = DEF_LEN_DEPTH,
    parameter int W     = LEN_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] iv_push_data,
    input  logic         i_pop,
    output logic [W-1:0] ov_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PW = ptr_w(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         push_ok;
    logic         pop_ok;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign ov_head = mem[rd_ptr[PW-1:0]];
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr[PW-1:0]] <= iv_push_data;
        end
    end

endmodule

// File: rtl/pkt_buf.sv
// rtl/pkt_buf.sv - store-and-forward packet buffer with drop counting
// Define PKT_BUF_LEN_HDR_EN to prefix each output packet with a length byte.
module pkt_buf
    import pkt_buf_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int MAX_PKT   = DEF_MAX_PKT,
    parameter int LEN_DEPTH = DEF_LEN_DEPTH
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [8:0] iv_data,
    input  logic       i_data_wr,
    output logic [7:0] ov_data,
    output logic       o_data_wr,
    output logic       o_sop,
    output logic       o_eop,
    output logic [7:0] ov_drop_cnt
);

    localparam int                AW      = ptr_w(DEPTH);
    localparam logic [AW:0]       DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [LEN_W:0]    MAX_LEN = (LEN_W+1)'(MAX_PKT);

    logic [7:0]       mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      commit_ptr;
    logic [AW:0]      rd_ptr;
    logic [LEN_W-1:0] wr_len;
    logic             dropping;

    logic             in_eop;
    logic [LEN_W:0]   next_len;
    logic             store_full;
    logic             drop_now;
    logic             accept;
    logic             len_push;
    logic             len_pop;
    logic             len_full;
    logic             len_empty;
    logic [LEN_W-1:0] len_head;

    rd_state_t        state;
    logic [LEN_W-1:0] rd_cnt;
    logic             last_byte;

    // Occupancy counts the uncommitted tail too, so a partial packet can fill the store.
    assign store_full = ((wr_ptr - rd_ptr) == DEPTH_W);
    assign last_byte  = ((rd_cnt + LEN_W'(1)) == len_head);
    assign len_pop    = (state == ST_SEND) && last_byte;

    always_comb begin
        in_eop   = iv_data[8];
        next_len = {1'b0, wr_len} + (LEN_W+1)'(1);
        drop_now = i_data_wr && !dropping &&
                   (store_full || (next_len > MAX_LEN) || (in_eop && len_full));
        accept   = i_data_wr && !dropping && !drop_now;
        len_push = accept && in_eop;
    end

    pkt_buf_len_fifo #(
        .DEPTH (LEN_DEPTH),
        .W     (LEN_W)
    ) u_len_fifo (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_push       (len_push),
        .iv_push_data (next_len[LEN_W-1:0]),
        .i_pop        (len_pop),
        .ov_head      (len_head),
        .o_full       (len_full),
        .o_empty      (len_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr      <= '0;
            commit_ptr  <= '0;
            wr_len      <= '0;
            dropping    <= 1'b0;
            ov_drop_cnt <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
                if (in_eop) begin
                    commit_ptr <= wr_ptr + (AW+1)'(1);
                    wr_len     <= '0;
                end else begin
                    wr_len <= next_len[LEN_W-1:0];
                end
            end
            // A drop on the EOP word itself has nothing left to discard.
            if (drop_now) begin
                wr_ptr   <= commit_ptr;
                wr_len   <= '0;
                dropping <= !in_eop;
                if (ov_drop_cnt != 8'hFF) begin
                    ov_drop_cnt <= ov_drop_cnt + 8'd1;
                end
            end
            if (i_data_wr && dropping && in_eop) begin
                dropping <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            mem[wr_ptr[AW-1:0]] <= iv_data[7:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            rd_ptr    <= '0;
            rd_cnt    <= '0;
            ov_data   <= '0;
            o_data_wr <= 1'b0;
            o_sop     <= 1'b0;
            o_eop     <= 1'b0;
        end else begin
            o_data_wr <= 1'b0;
            o_sop     <= 1'b0;
            o_eop     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    rd_cnt <= '0;
                    if (!len_empty) begin
`ifdef PKT_BUF_LEN_HDR_EN
                        state <= ST_HDR;
`else
                        state <= ST_SEND;
`endif
                    end
                end
`ifdef PKT_BUF_LEN_HDR_EN
                ST_HDR: begin
                    ov_data   <= {{(8-LEN_W){1'b0}}, len_head};
                    o_data_wr <= 1'b1;
                    o_sop     <= 1'b1;
                    state     <= ST_SEND;
                end
`endif
                ST_SEND: begin
                    ov_data   <= mem[rd_ptr[AW-1:0]];
                    o_data_wr <= 1'b1;
`ifndef PKT_BUF_LEN_HDR_EN
                    o_sop     <= (rd_cnt == '0);
`endif
                    o_eop     <= last_byte;
                    rd_ptr    <= rd_ptr + (AW+1)'(1);
                    rd_cnt    <= rd_cnt + LEN_W'(1);
                    if (last_byte) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
